alu_issue_rf: RTL and testbench

- Operand-issue stage that sits directly upstream of the 8-bit combinational ALU, drives its ctrl/x/y inputs and consumes its {carry, out} result.
- Holds an 8-entry x 8-bit register file and accepts register-to-register instructions over a valid/ready handshake.
- Registers the operands into a single EX stage, writes the ALU result back one cycle later and reports it on a registered result port.
- Forwarding from EX lets back-to-back dependent instructions issue every cycle without stalls.

---
 rtl/alu_issue_rf.sv | 132 +++++++++++++
 tb/tb_alu_issue_rf.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_rf.sv
`default_nettype none
// ============================================================================
// alu_issue_rf : 8 x 8 register file with one EX stage feeding an external
//                combinational ALU; EX-result forwarding, registered writeback.
// Revision     : 1.0
// ============================================================================
module alu_issue_rf #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic          alu_carry,
  input  logic [DW-1:0] alu_out,
  output logic          res_valid,
  output logic [AW-1:0] res_rd,
  output logic [DW-1:0] res_data,
  output logic          res_carry,
  output logic          carry_flag
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic          ex_valid_q, ex_valid_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [DW-1:0] alu_x_q, alu_x_d;
  logic [DW-1:0] alu_y_q, alu_y_d;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_rd_q, res_rd_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_carry_q, res_carry_d;
  logic          carry_flag_q, carry_flag_d;

  logic          issue;
  logic [DW-1:0] opnd1, opnd2;

  assign in_ready = ~ld_en;
  assign issue    = in_valid & ~ld_en;

  // The instruction in EX has not written back yet; take its result directly.
  assign opnd1 = (ex_valid_q && (in_rs1 == ex_rd_q)) ? alu_out : rf_q[in_rs1];
  assign opnd2 = (ex_valid_q && (in_rs2 == ex_rd_q)) ? alu_out : rf_q[in_rs2];

  always_comb begin
    rf_d         = rf_q;
    ex_valid_d   = issue;
    ex_rd_d      = ex_rd_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    res_valid_d  = ex_valid_q;
    res_rd_d     = res_rd_q;
    res_data_d   = res_data_q;
    res_carry_d  = res_carry_q;
    carry_flag_d = carry_flag_q;

    if (issue) begin
      ex_rd_d    = in_rd;
      alu_ctrl_d = in_op;
      alu_x_d    = opnd1;
      alu_y_d    = opnd2;
    end

    // Load first so a same-address writeback overrides it.
    if (ld_en) begin
      rf_d[ld_addr] = ld_data;
    end

    if (ex_valid_q) begin
      rf_d[ex_rd_q] = alu_out;
      res_rd_d      = ex_rd_q;
      res_data_d    = alu_out;
      res_carry_d   = alu_carry;
      carry_flag_d  = alu_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= '0;
      alu_ctrl_q   <= '0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      res_valid_q  <= 1'b0;
      res_rd_q     <= '0;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      res_valid_q  <= res_valid_d;
      res_rd_q     <= res_rd_d;
      res_data_q   <= res_data_d;
      res_carry_q  <= res_carry_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign alu_ctrl   = alu_ctrl_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign res_valid  = res_valid_q;
  assign res_rd     = res_rd_q;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign carry_flag = carry_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_rf.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_rf : self-checking bench for alu_issue_rf with an ALU model and
//                   an instruction-level reference model.
// Revision        : 1.0
// ============================================================================
module tb_alu_issue_rf;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, ld_en;
  logic [3:0] in_op, alu_ctrl;
  logic [2:0] in_rs1, in_rs2, in_rd, ld_addr, res_rd;
  logic [7:0] ld_data, alu_x, alu_y, alu_out, res_data;
  logic       alu_carry, res_valid, res_carry, carry_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_rf dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_carry(alu_carry), .alu_out(alu_out),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .res_carry(res_carry), .carry_flag(carry_flag)
  );

  // Returns {carry, out}
  function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    r = '0;
    case (c)
      4'd0:  r = {1'b0, x} + {1'b0, y};
      4'd1:  r = {1'b0, x} - {1'b0, y};
      4'd2:  r[7:0] = x & y;
      4'd3:  r[7:0] = x | y;
      4'd4:  r[7:0] = ~x;
      4'd5:  r[7:0] = x ^ y;
      4'd6:  r[7:0] = ~(x | y);
      4'd7:  r[7:0] = y << x[2:0];
      4'd8:  r[7:0] = y >> x[2:0];
      4'd9:  r[7:0] = {x[7], x[7:1]};
      4'd10: r[7:0] = {x[6:0], x[7]};
      4'd11: r[7:0] = {x[0], x[7:1]};
      4'd12: r = (x == y) ? 9'd1 : 9'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

  // Reference model: program-order register state plus the expected port values.
  logic [7:0] m_rf [8];
  logic       m_ex_v, m_res_v, m_res_carry, m_cflag;
  logic [2:0] m_ex_rd, m_res_rd;
  logic [3:0] m_ctrl;
  logic [7:0] m_x, m_y, m_res_data;
  logic [8:0] m_ex_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [2:0] la, input logic [7:0] ldd,
                     input logic v, input logic [3:0] op, input logic [2:0] s1,
                     input logic [2:0] s2, input logic [2:0] d);
    rst = r; ld_en = l; ld_addr = la; ld_data = ldd;
    in_valid = v; in_op = op; in_rs1 = s1; in_rs2 = s2; in_rd = d;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !l});
    if (r) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_ex_v = 0; m_ex_rd = 0; m_ctrl = 0; m_x = 0; m_y = 0;
      m_res_v = 0; m_res_rd = 0; m_res_data = 0; m_res_carry = 0; m_cflag = 0;
    end else begin
      m_res_v = m_ex_v;
      if (m_ex_v) begin
        m_res_rd = m_ex_rd; m_res_data = m_ex_res[7:0];
        m_res_carry = m_ex_res[8]; m_cflag = m_ex_res[8];
      end
      // The older in-flight instruction lands after the load if both hit one register.
      if (l && !(m_ex_v && m_ex_rd == la)) m_rf[la] = ldd;
      if (v && !l) begin
        m_ctrl = op; m_x = m_rf[s1]; m_y = m_rf[s2];
        m_ex_res = alu_f(op, m_x, m_y);
        m_rf[d] = m_ex_res[7:0];
        m_ex_rd = d; m_ex_v = 1;
      end else begin
        m_ex_v = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_res_v});
    chk("res_rd", {29'd0, res_rd}, {29'd0, m_res_rd});
    chk("res_data", {24'd0, res_data}, {24'd0, m_res_data});
    chk("res_carry", {31'd0, res_carry}, {31'd0, m_res_carry});
    chk("carry_flag", {31'd0, carry_flag}, {31'd0, m_cflag});
    chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_ctrl});
    chk("alu_x", {24'd0, alu_x}, {24'd0, m_x});
    chk("alu_y", {24'd0, alu_y}, {24'd0, m_y});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_x", {24'd0, alu_x}, 32'd0);
    chk("rst_carry_flag", {31'd0, carry_flag}, 32'd0);

    // Add with carry, then dependent sub forwarded from EX
    cyc(0, 1, 3'd1, 8'd200, 0, 0, 0, 0, 0);
    cyc(0, 1, 3'd2, 8'd100, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd0, 3'd1, 3'd2, 3'd3);
    cyc(0, 0, 0, 0, 1, 4'd1, 3'd3, 3'd1, 3'd4);
    chk("add_data", {24'd0, res_data}, 32'd44);
    chk("add_rd", {29'd0, res_rd}, 32'd3);
    chk("add_carry", {31'd0, res_carry}, 32'd1);
    chk("add_flag", {31'd0, carry_flag}, 32'd1);
    chk("fwd_x", {24'd0, alu_x}, 32'd44);
    chk("fwd_y", {24'd0, alu_y}, 32'd200);
    idle();
    chk("sub_valid", {31'd0, res_valid}, 32'd1);
    chk("sub_data", {24'd0, res_data}, 32'd100);
    chk("sub_carry", {31'd0, res_carry}, 32'd1);

    // Load/writeback collision with an instruction held during the load
    cyc(0, 0, 0, 0, 1, 4'd0, 3'd1, 3'd2, 3'd5);
    cyc(0, 1, 3'd5, 8'd7, 1, 4'd3, 3'd5, 3'd5, 3'd6);
    cyc(0, 0, 0, 0, 1, 4'd3, 3'd5, 3'd5, 3'd6);
    idle();
    chk("collide_rd", {29'd0, res_rd}, 32'd6);
    chk("collide_data", {24'd0, res_data}, 32'd44);

    // Opcode sweep
    cyc(0, 1, 3'd1, 8'h81, 0, 0, 0, 0, 0);
    cyc(0, 1, 3'd2, 8'h03, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd9,  3'd1, 3'd1, 3'd7);
    cyc(0, 0, 0, 0, 1, 4'd10, 3'd1, 3'd1, 3'd7);
    chk("op9", {24'd0, res_data}, 32'hC0);
    cyc(0, 0, 0, 0, 1, 4'd11, 3'd1, 3'd1, 3'd7);
    chk("op10", {24'd0, res_data}, 32'h03);
    cyc(0, 0, 0, 0, 1, 4'd7,  3'd2, 3'd1, 3'd7);
    chk("op11", {24'd0, res_data}, 32'hC0);
    cyc(0, 0, 0, 0, 1, 4'd12, 3'd1, 3'd1, 3'd7);
    chk("op7", {24'd0, res_data}, 32'h08);
    cyc(0, 0, 0, 0, 1, 4'd15, 3'd1, 3'd2, 3'd7);
    chk("op12", {24'd0, res_data}, 32'h01);
    idle();
    chk("op15_valid", {31'd0, res_valid}, 32'd1);
    chk("op15_data", {24'd0, res_data}, 32'h00);
    idle();

    // Reset during EX drops the instruction
    cyc(0, 0, 0, 0, 1, 4'd0, 3'd1, 3'd2, 3'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_data", {24'd0, res_data}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_novalid", {31'd0, res_valid}, 32'd0);
    cyc(0, 0, 0, 0, 1, 4'd3, 3'd0, 3'd0, 3'd6);
    idle();
    idle();

    // Outputs hold across idle cycles
    cyc(0, 1, 3'd1, 8'd200, 0, 0, 0, 0, 0);
    cyc(0, 1, 3'd2, 8'd100, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd0, 3'd1, 3'd2, 3'd3);
    for (int i = 0; i < 6; i++) idle();
    chk("hold_valid", {31'd0, res_valid}, 32'd0);
    chk("hold_data", {24'd0, res_data}, 32'd44);
    chk("hold_flag", {31'd0, carry_flag}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic       r, l, v;
      int         sel;
      r   = ($urandom_range(0, 79) == 0);
      sel = $urandom_range(0, 4);
      l   = (sel == 0);
      v   = (sel != 4) && (($urandom_range(0, 1) == 1) || !l);
      cyc(r, l, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), v,
          4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
